// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the Galois LFSR generator/checker family:
// checker state encoding and the feedback polynomial.
package lfsr_checker_pkg;

    localparam int LFSR_MIN_SIZE = 7;
    localparam int LFSR_MAX_SIZE = 64;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } checkState_e;

    // Galois form: N(s) = (s >> 1) ^ (s[0] ? mask : 0). Taps sit at
    // SIZE-1, SIZE-3, SIZE-4 and SIZE-6 (0xB400 for SIZE=16).
    function automatic logic [LFSR_MAX_SIZE-1:0] lfsrTapMask(input int size);
        logic [LFSR_MAX_SIZE-1:0] one;
        one = {{(LFSR_MAX_SIZE-1){1'b0}}, 1'b1};
        return (one << (size - 1)) | (one << (size - 3)) |
               (one << (size - 4)) | (one << (size - 6));
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Stream/status bundle between a word source (master) and the checker (slave).
interface lfsr_checker_if #(
    parameter int SIZE  = 16,
    parameter int ERR_W = 16
);
    logic             clear;
    logic             valid;
    logic [SIZE-1:0]  number;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output clear, valid, number,
        input  locked, error, err_cnt, state
    );

    modport slave (
        input  clear, valid, number,
        output locked, error, err_cnt, state
    );
endinterface

// File: rtl/lfsr_checker_step.sv
// Combinational one-step advance of the Galois LFSR; the same block is used
// by the generators so both sides agree on the polynomial.
module lfsr_checker_step
    import lfsr_checker_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] state_i,
    output logic [SIZE-1:0] next_o
);

    localparam logic [LFSR_MAX_SIZE-1:0] TAP_WIDE = lfsrTapMask(SIZE);
    localparam logic [SIZE-1:0]          TAPS     = TAP_WIDE[SIZE-1:0];

    assign next_o = (state_i >> 1) ^ (TAPS & {SIZE{state_i[0]}});

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker: seeds from the incoming stream, verifies successors until
// lock, then flywheels its own sequence and counts mismatching words.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int ERR_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int BR_W = $clog2(LOSS_CNT + 1);

    checkState_e      state_q;
    logic [SIZE-1:0]  expected_q;
    logic [MC_W-1:0]  matchCnt_q;
    logic [BR_W-1:0]  badRun_q;
    logic [ERR_W-1:0] errCnt_q;
    logic             error_q;

    logic [SIZE-1:0]  seedNext;
    logic [SIZE-1:0]  flyNext;
    logic [MC_W-1:0]  matchCnt_d;
    logic [BR_W-1:0]  badRun_d;
    logic [ERR_W-1:0] errCnt_d;
    logic             wordIsZero;
    logic             wordMatches;

    // Two steppers: one reseeds from the received word, one flywheels the
    // locally held expectation so corrupted input never pollutes it.
    lfsr_checker_step #(.SIZE(SIZE)) u_seedStep (
        .state_i (bus.number),
        .next_o  (seedNext)
    );

    lfsr_checker_step #(.SIZE(SIZE)) u_flyStep (
        .state_i (expected_q),
        .next_o  (flyNext)
    );

    assign wordIsZero  = (bus.number == '0);
    assign wordMatches = (bus.number == expected_q);
    assign matchCnt_d  = matchCnt_q + 1'b1;
    assign badRun_d    = badRun_q + 1'b1;
    assign errCnt_d    = (&errCnt_q) ? errCnt_q : errCnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            expected_q <= '0;
            matchCnt_q <= '0;
            badRun_q   <= '0;
            errCnt_q   <= '0;
            error_q    <= 1'b0;
        end else if (bus.clear) begin
            state_q    <= ST_SEARCH;
            matchCnt_q <= '0;
            badRun_q   <= '0;
            errCnt_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (bus.valid) begin
                unique case (state_q)
                    ST_SEARCH: begin
                        // All-zero is the LFSR lock-up state and cannot seed.
                        if (!wordIsZero) begin
                            expected_q <= seedNext;
                            matchCnt_q <= '0;
                            state_q    <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (wordIsZero) begin
                            state_q <= ST_SEARCH;
                        end else if (wordMatches) begin
                            expected_q <= seedNext;
                            matchCnt_q <= matchCnt_d;
                            if (matchCnt_d == MC_W'(LOCK_CNT)) begin
                                state_q  <= ST_LOCKED;
                                badRun_q <= '0;
                            end
                        end else begin
                            expected_q <= seedNext;
                            matchCnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        expected_q <= flyNext;
                        if (wordMatches) begin
                            badRun_q <= '0;
                        end else begin
                            error_q  <= 1'b1;
                            errCnt_q <= errCnt_d;
                            badRun_q <= badRun_d;
                            if (badRun_d == BR_W'(LOSS_CNT)) begin
                                state_q <= ST_SEARCH;
                            end
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    assign bus.locked  = (state_q == ST_LOCKED);
    assign bus.error   = error_q;
    assign bus.err_cnt = errCnt_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, error pulse, lock loss, stalls,
// zero words, saturation (ERR_W=4 instance), clear and reset.
module tb_lfsr_checker;

    logic clk;
    logic rst;
    int   compareCount;
    int   failCount;

    lfsr_checker_if #(.SIZE(16), .ERR_W(16)) busA ();
    lfsr_checker_if #(.SIZE(16), .ERR_W(4))  busB ();

    lfsr_checker #(.SIZE(16), .LOCK_CNT(4), .LOSS_CNT(8), .ERR_W(16)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    // Narrow-counter twin with a long loss threshold so it stays locked
    // through a long error burst.
    lfsr_checker #(.SIZE(16), .LOCK_CNT(4), .LOSS_CNT(32), .ERR_W(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    assign busB.clear  = busA.clear;
    assign busB.valid  = busA.valid;
    assign busB.number = busA.number;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsrModel(input logic [15:0] s);
        logic [15:0] n;
        n[15]  = s[0];
        n[14]  = s[15];
        n[13]  = s[0] ^ s[14];
        n[12]  = s[0] ^ s[13];
        n[11]  = s[12];
        n[10]  = s[0] ^ s[11];
        n[9:0] = s[10:1];
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] w, input logic clr);
        busA.valid  = v;
        busA.number = w;
        busA.clear  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        busA.valid = 1'b0;
        busA.clear = 1'b0;
        busA.number = 16'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] cur;
        logic [15:0] pattern;
        int          validCnt;
        compareCount = 0;
        failCount    = 0;
        rst          = 1'b1;
        busA.valid   = 1'b0;
        busA.clear   = 1'b0;
        busA.number  = 16'h0;

        doReset();
        checkOutput("rst_state",   32'(busA.state),   32'd0);
        checkOutput("rst_locked",  32'(busA.locked),  32'd0);
        checkOutput("rst_error",   32'(busA.error),   32'd0);
        checkOutput("rst_err_cnt", 32'(busA.err_cnt), 32'd0);

        // Acquisition with hand-computed successors of 0xACE1.
        applyStimulus(1'b1, 16'hACE1, 1'b0);
        checkOutput("seed_state", 32'(busA.state), 32'd1);
        applyStimulus(1'b1, 16'hE270, 1'b0);
        applyStimulus(1'b1, 16'h7138, 1'b0);
        applyStimulus(1'b1, 16'h389C, 1'b0);
        checkOutput("pre_lock", 32'(busA.locked), 32'd0);
        applyStimulus(1'b1, 16'h1C4E, 1'b0);
        checkOutput("lock_5th",      32'(busA.locked),  32'd1);
        checkOutput("lock_state",    32'(busA.state),   32'd2);
        checkOutput("lock_err_cnt",  32'(busA.err_cnt), 32'd0);

        // Single corrupted word: 0x0E27 sent as 0x0E26, then clean 0xB313.
        applyStimulus(1'b1, 16'h0E26, 1'b0);
        checkOutput("one_err_pulse", 32'(busA.error),   32'd1);
        checkOutput("one_err_cnt",   32'(busA.err_cnt), 32'd1);
        checkOutput("one_err_lock",  32'(busA.locked),  32'd1);
        applyStimulus(1'b1, 16'hB313, 1'b0);
        checkOutput("one_err_clr",   32'(busA.error),   32'd0);
        checkOutput("one_err_hold",  32'(busA.err_cnt), 32'd1);
        cur = 16'hB313;

        // Eight corrupted words drop lock on the eighth.
        for (int k = 1; k <= 8; k++) begin
            cur = lfsrModel(cur);
            applyStimulus(1'b1, cur ^ 16'h0001, 1'b0);
            checkOutput("burst_err",    32'(busA.error),   32'd1);
            checkOutput("burst_cnt",    32'(busA.err_cnt), 32'(1 + k));
            checkOutput("burst_locked", 32'(busA.locked),  (k < 8) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= 5; k++) begin
            cur = lfsrModel(cur);
            applyStimulus(1'b1, cur, 1'b0);
            checkOutput("relock", 32'(busA.locked), (k == 5) ? 32'd1 : 32'd0);
        end
        checkOutput("relock_cnt", 32'(busA.err_cnt), 32'd9);

        // Valid gaps: only valid words count, stalled wrong words are ignored.
        doReset();
        pattern  = 16'b1100_1101_0110_1011;
        cur      = 16'hACE1;
        validCnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (pattern[i]) begin
                applyStimulus(1'b1, cur, 1'b0);
                cur = lfsrModel(cur);
                validCnt++;
            end else begin
                applyStimulus(1'b0, 16'h5A5A, 1'b0);
            end
            checkOutput("gap_locked", 32'(busA.locked), (validCnt >= 5) ? 32'd1 : 32'd0);
            checkOutput("gap_error",  32'(busA.error),  32'd0);
        end
        checkOutput("gap_err_cnt", 32'(busA.err_cnt), 32'd0);

        // Zero word keeps or returns the checker to SEARCH.
        doReset();
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkOutput("zero_search", 32'(busA.state), 32'd0);
        applyStimulus(1'b1, 16'hACE1, 1'b0);
        checkOutput("zero_seed", 32'(busA.state), 32'd1);
        applyStimulus(1'b1, 16'h0000, 1'b0);
        checkOutput("zero_verify", 32'(busA.state),  32'd0);
        checkOutput("zero_locked", 32'(busA.locked), 32'd0);

        // Saturation on the 4-bit counter, then clear with a bad word.
        doReset();
        cur = 16'hACE1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, cur, 1'b0);
            cur = lfsrModel(cur);
        end
        checkOutput("sat_lockA", 32'(busA.locked), 32'd1);
        checkOutput("sat_lockB", 32'(busB.locked), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, cur ^ 16'h0001, 1'b0);
            cur = lfsrModel(cur);
            if (k == 14) checkOutput("sat_b_14", 32'(busB.err_cnt), 32'd14);
        end
        checkOutput("sat_b_cnt",    32'(busB.err_cnt), 32'd15);
        checkOutput("sat_b_locked", 32'(busB.locked),  32'd1);
        checkOutput("sat_a_cnt",    32'(busA.err_cnt), 32'd8);
        checkOutput("sat_a_locked", 32'(busA.locked),  32'd0);
        applyStimulus(1'b1, 16'h1234, 1'b1);
        checkOutput("clr_cnt_a",   32'(busA.err_cnt), 32'd0);
        checkOutput("clr_state_a", 32'(busA.state),   32'd0);
        checkOutput("clr_error_a", 32'(busA.error),   32'd0);
        checkOutput("clr_cnt_b",   32'(busB.err_cnt), 32'd0);
        checkOutput("clr_state_b", 32'(busB.state),   32'd0);
        checkOutput("clr_error_b", 32'(busB.error),   32'd0);

        // Reset taken while verifying.
        applyStimulus(1'b1, 16'hACE1, 1'b0);
        applyStimulus(1'b1, 16'hE270, 1'b0);
        checkOutput("mid_verify", 32'(busA.state), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h7138, 1'b0);
        rst = 1'b0;
        checkOutput("mid_rst_state",  32'(busA.state),   32'd0);
        checkOutput("mid_rst_locked", 32'(busA.locked),  32'd0);
        checkOutput("mid_rst_error",  32'(busA.error),   32'd0);
        checkOutput("mid_rst_cnt",    32'(busA.err_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
